// File: rtl/mac_dot_sequencer.sv
// Command-driven unsigned MAC sequencer: one dot product of programmable length per start,
// valid/ready operand stream in, result plus sticky carry-out held on a result handshake.
module mac_dot_sequencer #(
  parameter int M     = 8,
  parameter int N     = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     a_in,
  input  logic [N-1:0]     b_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [M+N-1:0]   result,
  output logic             cout,
  output logic [LEN_W-1:0] count
);

  localparam int W = M + N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic             cout_q, cout_d;
  logic [LEN_W-1:0] count_q, count_d;

  logic [W-1:0]     prod;
  logic [W:0]       sum;
  logic             beat;

  // Product is full width; only the running sum can wrap, and its carry feeds cout.
  assign prod = W'(a_in) * W'(b_in);
  assign sum  = {1'b0, acc_q} + {1'b0, prod};

  // Handshake outputs depend on state alone, never on in_valid.
  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == ACC);
  assign res_valid = (state_q == DONE);
  assign result    = acc_q;
  assign cout      = cout_q;
  assign count     = count_q;

  assign beat = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cout_d  = cout_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cout_d  = 1'b0;
          count_d = len;
          state_d = (len != '0) ? ACC : DONE;
        end
      end
      ACC: begin
        if (abort) begin
          state_d = IDLE;
        end else if (beat) begin
          acc_d   = sum[W-1:0];
          cout_d  = cout_q | sum[W];
          count_d = count_q - LEN_W'(1);
          if (count_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (abort || res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cout_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cout_q  <= cout_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer: hand-written reset sequence, then a per-cycle vector table.
module tb_mac_dot_sequencer;

  localparam int M     = 8;
  localparam int N     = 8;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [M-1:0]     a_in;
  logic [N-1:0]     b_in;
  logic             res_valid;
  logic             res_ready;
  logic [M+N-1:0]   result;
  logic             cout;
  logic [LEN_W-1:0] count;

  mac_dot_sequencer #(.M(M), .N(N), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .cout      (cout),
    .count     (count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        st;
    logic [7:0]  ln;
    logic        ab;
    logic        iv;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        rr;
    logic        e_busy;
    logic        e_irdy;
    logic        e_rv;
    logic [15:0] e_res;
    logic        e_co;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_busy, input logic e_irdy,
                         input logic e_rv, input logic [15:0] e_res, input logic e_co,
                         input logic [7:0] e_cnt);
    chk({tag, " busy"},      32'(busy),      32'(e_busy));
    chk({tag, " in_ready"},  32'(in_ready),  32'(e_irdy));
    chk({tag, " res_valid"}, 32'(res_valid), 32'(e_rv));
    chk({tag, " result"},    32'(result),    32'(e_res));
    chk({tag, " cout"},      32'(cout),      32'(e_co));
    chk({tag, " count"},     32'(count),     32'(e_cnt));
  endtask

  task automatic add(input logic st, input int ln, input logic ab, input logic iv,
                     input int a, input int b, input logic rr,
                     input logic e_busy, input logic e_irdy, input logic e_rv,
                     input int e_res, input logic e_co, input int e_cnt);
    vec_t v;
    v.st = st;  v.ln = 8'(ln);  v.ab = ab;  v.iv = iv;
    v.a = 8'(a);  v.b = 8'(b);  v.rr = rr;
    v.e_busy = e_busy;  v.e_irdy = e_irdy;  v.e_rv = e_rv;
    v.e_res = 16'(e_res);  v.e_co = e_co;  v.e_cnt = 8'(e_cnt);
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input logic [7:0] ln, input logic ab, input logic iv,
                       input logic [7:0] a, input logic [7:0] b, input logic rr);
    start = st;  len = ln;  abort = ab;  in_valid = iv;
    a_in = a;  b_in = b;  res_ready = rr;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    #12;
    chk_all("reset_held", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reach ACC with count=2 and a nonzero partial sum, then reset between edges.
    drive(1'b1, 8'd3, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    drive(1'b0, 8'd0, 1'b0, 1'b1, 8'd2, 8'd3, 1'b0);
    @(posedge clk); #1;
    chk_all("pre_rst", 1'b1, 1'b1, 1'b0, 16'd6, 1'b0, 8'd2);
    @(negedge clk);
    drive(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_all("post_rst", 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 8'd0);

    //   st ln ab iv   a    b  rr | busy irdy rv   res  co cnt
    // basic dot product
    add(1,  3, 0, 0,   0,   0, 0,   1, 1, 0,     0, 0, 3);
    add(0,  0, 0, 1,   2,   3, 0,   1, 1, 0,     6, 0, 2);
    add(0,  0, 0, 1,   4,   5, 0,   1, 1, 0,    26, 0, 1);
    add(0,  0, 0, 1, 255, 255, 0,   1, 0, 1, 65051, 0, 0);
    add(0,  0, 0, 0,   0,   0, 1,   0, 0, 0, 65051, 0, 0);
    // overflow with a 3-cycle gap, then 5 cycles of backpressure
    add(1,  2, 0, 0,   0,   0, 0,   1, 1, 0,     0, 0, 2);
    add(0,  0, 0, 1, 255, 255, 0,   1, 1, 0, 65025, 0, 1);
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 0, 255, 255, 0,  1, 1, 0, 65025, 0, 1);
    add(0,  0, 0, 1, 255, 255, 0,   1, 0, 1, 64514, 1, 0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 1,  17,  19, 0,  1, 0, 1, 64514, 1, 0);
    add(0,  0, 0, 0,   0,   0, 1,   0, 0, 0, 64514, 1, 0);
    // zero length
    add(1,  0, 0, 1,   9,   9, 0,   1, 0, 1,     0, 0, 0);
    add(0,  0, 0, 1,   9,   9, 1,   0, 0, 0,     0, 0, 0);
    // abort on the 2nd beat, then a fresh len=1 command
    add(1,  4, 0, 0,   0,   0, 0,   1, 1, 0,     0, 0, 4);
    add(0,  0, 0, 1,   3,   3, 0,   1, 1, 0,     9, 0, 3);
    add(0,  0, 1, 1,   5,   5, 0,   0, 0, 0,     9, 0, 3);
    add(0,  0, 0, 1,   5,   5, 0,   0, 0, 0,     9, 0, 3);
    add(1,  1, 0, 0,   0,   0, 0,   1, 1, 0,     0, 0, 1);
    add(0,  0, 0, 1,   7,   9, 0,   1, 0, 1,    63, 0, 0);
    add(0,  0, 0, 0,   0,   0, 1,   0, 0, 0,    63, 0, 0);
    // start ignored in ACC and DONE; back-to-back commands one IDLE cycle apart
    add(1,  2, 0, 0,   0,   0, 0,   1, 1, 0,     0, 0, 2);
    add(1,  5, 0, 1,   1,   1, 0,   1, 1, 0,     1, 0, 1);
    add(1,  5, 0, 1,   2,   2, 0,   1, 0, 1,     5, 0, 0);
    add(1,  7, 0, 0,   0,   0, 1,   0, 0, 0,     5, 0, 0);
    add(1,  1, 0, 0,   0,   0, 1,   1, 1, 0,     0, 0, 1);
    add(0,  0, 0, 1,  10,  10, 1,   1, 0, 1,   100, 0, 0);
    add(0,  0, 0, 0,   0,   0, 1,   0, 0, 0,   100, 0, 0);
    // abort in DONE, abort ignored in IDLE
    add(1,  0, 0, 0,   0,   0, 0,   1, 0, 1,     0, 0, 0);
    add(0,  0, 1, 0,   0,   0, 0,   0, 0, 0,     0, 0, 0);
    add(1,  1, 1, 0,   0,   0, 0,   1, 1, 0,     0, 0, 1);
    add(0,  0, 0, 1,   2,   2, 0,   1, 0, 1,     4, 0, 0);
    add(0,  0, 0, 0,   0,   0, 1,   0, 0, 0,     4, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].st, vecs[i].ln, vecs[i].ab, vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].rr);
      @(posedge clk); #1;
      chk_all($sformatf("row%0d", i), vecs[i].e_busy, vecs[i].e_irdy, vecs[i].e_rv,
              vecs[i].e_res, vecs[i].e_co, vecs[i].e_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
